am25ls2521_matchctl: RTL and testbench



---
 rtl/am25ls2521_matchctl_pkg.sv | 37 +++
 rtl/am25ls2521.sv | 14 +
 rtl/am25ls2521_matchctl_cnt.sv | 29 ++
 rtl/am25ls2521_matchctl.sv | 95 +++++++++
 tb/tb_am25ls2521_matchctl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/am25ls2521_matchctl_pkg.sv
// Shared types for the am25ls2521 match controller:
// state encodings and the prioritised command decode.
package am25ls2521_matchctl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_HIT   = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_LOAD  = 2'd1,
        CMD_ABORT = 2'd2,
        CMD_MATCH = 2'd3
    } cmd_t;

    // Load beats abort beats match; eq_ is only looked at under strb.
    function automatic cmd_t decode_cmd(
        input logic ld_n,
        input logic nz,
        input logic strb,
        input logic eq_n
    );
        cmd_t c;
        if (!ld_n && nz)
            c = CMD_LOAD;
        else if (!ld_n)
            c = CMD_ABORT;
        else if (strb && !eq_n)
            c = CMD_MATCH;
        else
            c = CMD_NONE;
        return c;
    endfunction

endpackage

// File: rtl/am25ls2521.sv
// Cascadable equality comparator slice (am25ls2521 style):
// eout_ is low only when enabled and a equals b.
module am25ls2521 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ein_,
    output logic             eout_
);

    assign eout_ = ein_ | (a != b);

endmodule

// File: rtl/am25ls2521_matchctl_cnt.sv
// Loadable down-counter for the match controller;
// flags q==1 so the FSM knows the next match is the last.
module am25ls2521_matchctl_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr_,
    input  logic             ld,
    input  logic             dec,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             one
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge clr_) begin
        if (!clr_)
            r_q <= '0;
        else if (ld)
            r_q <= d;
        else if (dec)
            r_q <= r_q - 1'b1;
    end

    assign q   = r_q;
    assign one = (r_q == WIDTH'(1));

endmodule

// File: rtl/am25ls2521_matchctl.sv
// Match controller: arms on a nonzero load, counts qualified
// comparator matches down, then holds a latched hit until acked.
module am25ls2521_matchctl
    import am25ls2521_matchctl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr_,
    input  logic             eq_,
    input  logic             strb,
    input  logic             ld_,
    input  logic [WIDTH-1:0] cnt_d,
    input  logic             ack_,
    output logic             cmp_en_,
    output logic             hit_,
    output logic             busy,
    output logic [WIDTH-1:0] cnt_q
);

    state_t r_state;
    state_t w_state_nxt;
    cmd_t   w_cmd;
    logic   w_ld;
    logic   w_dec;
    logic   w_one;

    assign w_cmd = decode_cmd(ld_, |cnt_d, strb, eq_);

    always_ff @(posedge clk or negedge clr_) begin
        if (!clr_)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ld        = 1'b0;
        w_dec       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd == CMD_LOAD) begin
                    w_ld        = 1'b1;
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                case (w_cmd)
                    CMD_LOAD:  w_ld = 1'b1;
                    CMD_ABORT: w_state_nxt = ST_IDLE;
                    CMD_MATCH: begin
                        w_dec = 1'b1;
                        if (w_one)
                            w_state_nxt = ST_HIT;
                    end
                    default: ;
                endcase
            end
            ST_HIT: begin
                if (!ack_)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Pure decode of the state register; 2'b11 looks like IDLE.
    always_comb begin
        cmp_en_ = 1'b1;
        hit_    = 1'b1;
        busy    = 1'b0;
        case (r_state)
            ST_ARMED: begin
                cmp_en_ = 1'b0;
                busy    = 1'b1;
            end
            ST_HIT:  hit_ = 1'b0;
            default: ;
        endcase
    end

    am25ls2521_matchctl_cnt #(
        .WIDTH(WIDTH)
    ) u_cnt (
        .clk (clk),
        .clr_(clr_),
        .ld  (w_ld),
        .dec (w_dec),
        .d   (cnt_d),
        .q   (cnt_q),
        .one (w_one)
    );

endmodule

// File: tb/tb_am25ls2521_matchctl.sv
// Directed bench: comparator slice feeding the match controller,
// checking {cmp_en_, hit_, busy, cnt_q} after each edge.
module tb_am25ls2521_matchctl;

    logic       clk = 1'b0;
    logic       clr_;
    logic       strb;
    logic       ld_;
    logic [7:0] cnt_d;
    logic       ack_;
    logic [7:0] a;
    logic [7:0] b;
    logic       eq_;
    logic       cmp_en_;
    logic       hit_;
    logic       busy;
    logic [7:0] cnt_q;
    logic [10:0] obs;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    am25ls2521 #(.WIDTH(8)) u_cmp (
        .a    (a),
        .b    (b),
        .ein_ (cmp_en_),
        .eout_(eq_)
    );

    am25ls2521_matchctl #(.WIDTH(8)) dut (
        .clk    (clk),
        .clr_   (clr_),
        .eq_    (eq_),
        .strb   (strb),
        .ld_    (ld_),
        .cnt_d  (cnt_d),
        .ack_   (ack_),
        .cmp_en_(cmp_en_),
        .hit_   (hit_),
        .busy   (busy),
        .cnt_q  (cnt_q)
    );

    assign obs = {cmp_en_, hit_, busy, cnt_q};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        strb  = 1'b0;
        ld_   = 1'b1;
        ack_  = 1'b1;
        cnt_d = 8'd0;
    endtask

    task automatic test_reset();
        clr_ = 1'b0;
        idle_inputs();
        a = 8'h00;
        b = 8'h00;
        #1;
        total++;
        if (obs !== {3'b110, 8'd0}) begin
            bad++;
            $display("FAIL reset: got %b want %b", obs, {3'b110, 8'd0});
        end
        step();
        clr_ = 1'b1;
        step();
        total++;
        if (obs !== {3'b110, 8'd0}) begin
            bad++;
            $display("FAIL reset_release: got %b want %b", obs, {3'b110, 8'd0});
        end
    endtask

    task automatic test_reset_mid_armed();
        ld_ = 1'b0; cnt_d = 8'd3;
        step();
        total++;
        if (obs !== {3'b011, 8'd3}) begin
            bad++;
            $display("FAIL rma_load: got %b want %b", obs, {3'b011, 8'd3});
        end
        ld_ = 1'b1; a = 8'hA5; b = 8'hA5; strb = 1'b1;
        step();
        total++;
        if (obs !== {3'b011, 8'd2}) begin
            bad++;
            $display("FAIL rma_match: got %b want %b", obs, {3'b011, 8'd2});
        end
        clr_ = 1'b0;
        #1;
        total++;
        if (obs !== {3'b110, 8'd0}) begin
            bad++;
            $display("FAIL rma_async: got %b want %b", obs, {3'b110, 8'd0});
        end
        idle_inputs();
        step();
        clr_ = 1'b1;
        step();
    endtask

    task automatic test_count_to_hit();
        logic [10:0] exp [3];
        exp[0] = {3'b011, 8'd2};
        exp[1] = {3'b011, 8'd1};
        exp[2] = {3'b100, 8'd0};
        ld_ = 1'b0; cnt_d = 8'd3;
        step();
        total++;
        if (obs !== {3'b011, 8'd3}) begin
            bad++;
            $display("FAIL c2h_load: got %b want %b", obs, {3'b011, 8'd3});
        end
        ld_ = 1'b1; a = 8'hA5; b = 8'hA5; strb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (obs !== exp[i]) begin
                bad++;
                $display("FAIL c2h_step%0d: got %b want %b", i, obs, exp[i]);
            end
        end
        strb = 1'b0;
        step();
        total++;
        if (obs !== {3'b100, 8'd0}) begin
            bad++;
            $display("FAIL c2h_hold: got %b want %b", obs, {3'b100, 8'd0});
        end
        ack_ = 1'b0;
        step();
        total++;
        if (obs !== {3'b110, 8'd0}) begin
            bad++;
            $display("FAIL c2h_ack: got %b want %b", obs, {3'b110, 8'd0});
        end
        ack_ = 1'b1;
    endtask

    task automatic test_miss_and_abort();
        ld_ = 1'b0; cnt_d = 8'd2;
        step();
        ld_ = 1'b1; cnt_d = 8'd0;
        a = 8'hA5; b = 8'hA4; strb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (obs !== {3'b011, 8'd2}) begin
                bad++;
                $display("FAIL miss%0d: got %b want %b", i, obs, {3'b011, 8'd2});
            end
        end
        b = 8'hA5; strb = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (obs !== {3'b011, 8'd2}) begin
                bad++;
                $display("FAIL nostrb%0d: got %b want %b", i, obs, {3'b011, 8'd2});
            end
        end
        ld_ = 1'b0; cnt_d = 8'd0;
        step();
        total++;
        if (obs !== {3'b110, 8'd2}) begin
            bad++;
            $display("FAIL abort: got %b want %b", obs, {3'b110, 8'd2});
        end
        step();
        total++;
        if (obs !== {3'b110, 8'd2}) begin
            bad++;
            $display("FAIL zero_load_idle: got %b want %b", obs, {3'b110, 8'd2});
        end
        ld_ = 1'b1;
        step();
    endtask

    task automatic test_reload();
        ld_ = 1'b0; cnt_d = 8'd1;
        step();
        total++;
        if (obs !== {3'b011, 8'd1}) begin
            bad++;
            $display("FAIL rl_load: got %b want %b", obs, {3'b011, 8'd1});
        end
        cnt_d = 8'd5; a = 8'h3C; b = 8'h3C; strb = 1'b1;
        step();
        total++;
        if (obs !== {3'b011, 8'd5}) begin
            bad++;
            $display("FAIL rl_prio: got %b want %b", obs, {3'b011, 8'd5});
        end
        ld_ = 1'b1;
        step();
        total++;
        if (obs !== {3'b011, 8'd4}) begin
            bad++;
            $display("FAIL rl_count: got %b want %b", obs, {3'b011, 8'd4});
        end
        strb = 1'b0; ld_ = 1'b0; cnt_d = 8'd0;
        step();
        ld_ = 1'b1;
    endtask

    task automatic test_hit_handshake();
        ld_ = 1'b0; cnt_d = 8'd1;
        step();
        ld_ = 1'b1; a = 8'hFF; b = 8'hFF; strb = 1'b1;
        step();
        strb = 1'b0;
        total++;
        if (obs !== {3'b100, 8'd0}) begin
            bad++;
            $display("FAIL hs_hit: got %b want %b", obs, {3'b100, 8'd0});
        end
        ld_ = 1'b0; cnt_d = 8'd4;
        step();
        total++;
        if (obs !== {3'b100, 8'd0}) begin
            bad++;
            $display("FAIL hs_ld_ignored: got %b want %b", obs, {3'b100, 8'd0});
        end
        ack_ = 1'b0;
        step();
        total++;
        if (obs !== {3'b110, 8'd0}) begin
            bad++;
            $display("FAIL hs_ack_ld: got %b want %b", obs, {3'b110, 8'd0});
        end
        ld_ = 1'b1;
        step();
        total++;
        if (obs !== {3'b110, 8'd0}) begin
            bad++;
            $display("FAIL hs_ack_held: got %b want %b", obs, {3'b110, 8'd0});
        end
        ack_ = 1'b1;
    endtask

    initial begin
        test_reset();
        test_reset_mid_armed();
        test_count_to_hit();
        test_miss_and_abort();
        test_reload();
        test_hit_handshake();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
